// File: rtl/blk_rx_chk.sv
// rtl/blk_rx_chk.sv - loop-back receive checker for an incrementing 8-bit byte counter
module blk_rx_chk #(
    parameter int BLOCK_LEN   = 1152,
    parameter int SYNC_LEN    = 4,
    parameter int LOSS_THRESH = 3,
    parameter int ERR_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_rx_dv,
    input  logic [7:0]       i_rx_byte,
    input  logic             i_clr_err,
    output logic             o_locked,
    output logic             o_err_pulse,
    output logic [ERR_W-1:0] o_err_cnt,
    output logic             o_led
);

    localparam int RUN_W = $clog2(SYNC_LEN + 1);
    localparam int BAD_W = $clog2(LOSS_THRESH + 1);
    localparam int BLK_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;

    // Comparing the current count against N-1 is the same test as "count+1 == N".
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(SYNC_LEN - 1);
    localparam logic [BAD_W-1:0] BAD_LAST = BAD_W'(LOSS_THRESH - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLOCK_LEN - 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state;
    logic [7:0]       exp_byte;
    logic [RUN_W-1:0] run;
    logic [BAD_W-1:0] bad;
    logic [BLK_W-1:0] blk;

    logic match;
    assign match = (i_rx_byte == exp_byte);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= HUNT;
            exp_byte    <= '0;
            run         <= '0;
            bad         <= '0;
            blk         <= '0;
            o_locked    <= 1'b0;
            o_err_pulse <= 1'b0;
            o_err_cnt   <= '0;
            o_led       <= 1'b0;
        end else begin
            o_err_pulse <= 1'b0;
            // A mismatch below overrides this with 1 when both land together.
            if (i_clr_err) begin
                o_err_cnt <= '0;
            end

            if (i_rx_dv) begin
                case (state)
                    HUNT: begin
                        exp_byte <= i_rx_byte + 8'd1;
                        run      <= RUN_W'(1);
                        state    <= SYNC;
                    end

                    SYNC: begin
                        if (match) begin
                            exp_byte <= exp_byte + 8'd1;
                            run      <= run + RUN_W'(1);
                            if (run == RUN_LAST) begin
                                state    <= LOCKED;
                                o_locked <= 1'b1;
                                blk      <= '0;
                                bad      <= '0;
                            end
                        end else begin
                            // Restart the run on whatever arrived; no error outside LOCKED.
                            exp_byte <= i_rx_byte + 8'd1;
                            run      <= RUN_W'(1);
                        end
                    end

                    LOCKED: begin
                        if (match) begin
                            exp_byte <= exp_byte + 8'd1;
                            bad      <= '0;
                        end else begin
                            o_err_pulse <= 1'b1;
                            if (i_clr_err) begin
                                o_err_cnt <= ERR_W'(1);
                            end else if (!(&o_err_cnt)) begin
                                o_err_cnt <= o_err_cnt + ERR_W'(1);
                            end
                            // Resync to the received value so one dropped byte costs one error.
                            exp_byte <= i_rx_byte + 8'd1;
                            bad      <= bad + BAD_W'(1);
                        end

                        if (!match && bad == BAD_LAST) begin
                            // Losing lock freezes blk and o_led where they are.
                            state    <= HUNT;
                            o_locked <= 1'b0;
                        end else if (blk == BLK_LAST) begin
                            blk   <= '0;
                            o_led <= ~o_led;
                        end else begin
                            blk <= blk + BLK_W'(1);
                        end
                    end

                    default: begin
                        state    <= HUNT;
                        o_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_blk_rx_chk.sv
// tb/tb_blk_rx_chk.sv - self-checking bench for blk_rx_chk against a behavioural model
module tb_blk_rx_chk;

    localparam int BLOCK_LEN   = 1152;
    localparam int SYNC_LEN    = 4;
    localparam int LOSS_THRESH = 3;
    localparam int ERR_W       = 4;
    localparam int CNT_MAX     = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             rx_dv = 1'b0;
    logic [7:0]       rx_byte = 8'h00;
    logic             clr_err = 1'b0;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_cnt;
    logic             led;

    blk_rx_chk #(
        .BLOCK_LEN  (BLOCK_LEN),
        .SYNC_LEN   (SYNC_LEN),
        .LOSS_THRESH(LOSS_THRESH),
        .ERR_W      (ERR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rx_dv    (rx_dv),
        .i_rx_byte  (rx_byte),
        .i_clr_err  (clr_err),
        .o_locked   (locked),
        .o_err_pulse(err_pulse),
        .o_err_cnt  (err_cnt),
        .o_led      (led)
    );

    always #5 clk = ~clk;

    // Model: mode 0 = hunting, 1 = building a run, 2 = locked.
    int m_mode, m_exp, m_run, m_bad, m_blk, m_led, m_cnt, m_pulse;
    int n_pass = 0;
    int n_total = 0;

    function automatic void model_reset();
        m_mode = 0; m_exp = 0; m_run = 0; m_bad = 0;
        m_blk = 0; m_led = 0; m_cnt = 0; m_pulse = 0;
    endfunction

    function automatic void model_blk_tick();
        m_blk = m_blk + 1;
        if (m_blk == BLOCK_LEN) begin
            m_blk = 0;
            m_led = 1 - m_led;
        end
    endfunction

    function automatic void model_byte(input bit dv, input int b, input bit clr);
        m_pulse = 0;
        if (clr) m_cnt = 0;
        if (!dv) return;
        if (m_mode == 0) begin
            m_exp = (b + 1) % 256; m_run = 1; m_mode = 1;
        end else if (m_mode == 1) begin
            if (b == m_exp) begin
                m_exp = (m_exp + 1) % 256;
                m_run = m_run + 1;
                if (m_run == SYNC_LEN) begin
                    m_mode = 2; m_blk = 0; m_bad = 0;
                end
            end else begin
                m_exp = (b + 1) % 256; m_run = 1;
            end
        end else begin
            if (b == m_exp) begin
                m_exp = (m_exp + 1) % 256;
                m_bad = 0;
                model_blk_tick();
            end else begin
                m_pulse = 1;
                m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
                m_exp = (b + 1) % 256;
                m_bad = m_bad + 1;
                if (m_bad == LOSS_THRESH) m_mode = 0;
                else model_blk_tick();
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic chk_all(input string where);
        chk({where, ":locked"}, 32'(locked), 32'(m_mode == 2));
        chk({where, ":pulse"}, 32'(err_pulse), 32'(m_pulse));
        chk({where, ":cnt"}, 32'(err_cnt), 32'(m_cnt));
        chk({where, ":led"}, 32'(led), 32'(m_led));
    endtask

    // Called at a negedge; leaves the bench at the following negedge.
    task automatic step(input bit dv, input logic [7:0] b, input bit clr, input string where);
        rx_dv = dv; rx_byte = b; clr_err = clr;
        @(posedge clk);
        model_byte(dv, int'(b), clr);
        @(negedge clk);
        rx_dv = 1'b0; clr_err = 1'b0;
        chk_all(where);
    endtask

    task automatic do_reset(input string where);
        rst_n = 1'b0; rx_dv = 1'b1; rx_byte = 8'($urandom); clr_err = 1'b1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; rx_dv = 1'b0; clr_err = 1'b0;
        chk_all(where);
    endtask

    task automatic send_run(input logic [7:0] first, input int n, input string where);
        for (int i = 0; i < n; i++) step(1'b1, first + 8'(i), 1'b0, where);
    endtask

    task automatic stream_seq(input int n, input int gap, input string where);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 8'(m_exp), 1'b0, where);
            for (int g = 0; g < gap; g++) step(1'b0, 8'($urandom), 1'b0, where);
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset("reset");
        chk("reset_locked", 32'(locked), 32'd0);
        chk("reset_cnt", 32'(err_cnt), 32'd0);

        // Acquire on 10..13; lock appears only after the fourth byte.
        send_run(8'h10, 3, "acq");
        chk("pre_lock", 32'(locked), 32'd0);
        step(1'b1, 8'h13, 1'b0, "acq4");
        chk("lock_after_13", 32'(locked), 32'd1);
        chk("lock_led", 32'(led), 32'd0);

        // Counter wrap FF->00 is not an error.
        do_reset("reset2");
        send_run(8'hFA, 8, "wrap");
        chk("wrap_locked", 32'(locked), 32'd1);
        chk("wrap_cnt", 32'(err_cnt), 32'd0);

        // One dropped byte costs exactly one error.
        do_reset("reset3");
        send_run(8'h1C, 6, "drop_pre");
        step(1'b1, 8'h23, 1'b0, "drop23");
        chk("drop_pulse_on_23", 32'(err_pulse), 32'd1);
        step(1'b1, 8'h24, 1'b0, "drop24");
        chk("drop_cnt", 32'(err_cnt), 32'd1);
        chk("drop_locked", 32'(locked), 32'd1);

        // Three consecutive mismatches drop lock; four sequential bytes relock.
        do_reset("reset4");
        send_run(8'h1D, 4, "loss_pre");
        step(1'b1, 8'h40, 1'b0, "loss1");
        step(1'b1, 8'h80, 1'b0, "loss2");
        chk("loss2_locked", 32'(locked), 32'd1);
        step(1'b1, 8'hC0, 1'b0, "loss3");
        chk("loss3_pulse", 32'(err_pulse), 32'd1);
        chk("loss3_locked", 32'(locked), 32'd0);
        chk("loss3_cnt", 32'(err_cnt), 32'd3);
        send_run(8'h50, 3, "relock");
        chk("relock_pre", 32'(locked), 32'd0);
        step(1'b1, 8'h53, 1'b0, "relock4");
        chk("relock_locked", 32'(locked), 32'd1);

        // LED period, back-to-back strobes.
        do_reset("reset5");
        send_run(8'h00, 4, "led_lock");
        stream_seq(BLOCK_LEN - 1, 0, "led_b2b");
        chk("led_b2b_1151", 32'(led), 32'd0);
        stream_seq(1, 0, "led_b2b");
        chk("led_b2b_1152", 32'(led), 32'd1);
        stream_seq(BLOCK_LEN, 0, "led_b2b");
        chk("led_b2b_2304", 32'(led), 32'd0);

        // Same with three idle clocks between bytes.
        do_reset("reset6");
        send_run(8'h00, 4, "gap_lock");
        stream_seq(BLOCK_LEN - 1, 3, "led_gap");
        chk("led_gap_1151", 32'(led), 32'd0);
        stream_seq(1, 3, "led_gap");
        chk("led_gap_1152", 32'(led), 32'd1);
        stream_seq(BLOCK_LEN, 3, "led_gap");
        chk("led_gap_2304", 32'(led), 32'd0);

        // Clear coincident with a mismatch, then saturation.
        do_reset("reset7");
        send_run(8'h00, 4, "clr_lock");
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'(m_exp) ^ 8'h80, 1'b0, "clr_err");
            step(1'b1, 8'(m_exp), 1'b0, "clr_ok");
        end
        chk("cnt_is_5", 32'(err_cnt), 32'd5);
        step(1'b1, 8'(m_exp) ^ 8'h80, 1'b1, "clr_mis");
        chk("clr_mis_cnt", 32'(err_cnt), 32'd1);
        chk("clr_mis_pulse", 32'(err_pulse), 32'd1);
        step(1'b0, 8'h00, 1'b1, "clr_idle");
        chk("clr_idle_cnt", 32'(err_cnt), 32'd0);
        for (int i = 0; i < CNT_MAX + 5; i++) begin
            step(1'b1, 8'(m_exp) ^ 8'h01, 1'b0, "sat_err");
            step(1'b1, 8'(m_exp), 1'b0, "sat_ok");
        end
        chk("sat_cnt", 32'(err_cnt), 32'(CNT_MAX));

        // Randomised traffic: mostly in-sequence with errors, gaps and clears.
        for (int i = 0; i < 3000; i++) begin
            bit dv, clr;
            logic [7:0] b;
            dv  = ($urandom_range(0, 3) != 0);
            b   = ($urandom_range(0, 9) < 8) ? 8'(m_exp) : 8'($urandom);
            clr = ($urandom_range(0, 49) == 0);
            step(dv, b, clr, "rand");
        end

        // Reset mid-stream while locked.
        do_reset("reset8");
        send_run(8'h30, 10, "mid_lock");
        step(1'b1, 8'h00, 1'b0, "mid_err");
        chk("mid_locked", 32'(locked), 32'd1);
        do_reset("mid_reset");
        chk("mid_reset_locked", 32'(locked), 32'd0);
        chk("mid_reset_cnt", 32'(err_cnt), 32'd0);
        chk("mid_reset_pulse", 32'(err_pulse), 32'd0);
        send_run(8'h77, 3, "post_reset");
        chk("post_reset_hunt", 32'(locked), 32'd0);
        step(1'b1, 8'h7A, 1'b0, "post_reset4");
        chk("post_reset_lock", 32'(locked), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
